// File: rtl/sm3_hash_varlen.sv
// SM3 digest of a variable-length, MSB-aligned message: pads internally and chains the
// padded 512-bit blocks through one iterative 64-round compression core.
module sm3_hash_varlen #(
   parameter int unsigned MAX_MSG_BITS = 768,
   parameter int unsigned LEN_W        = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [MAX_MSG_BITS-1:0] msg,
   input  logic [LEN_W-1:0]        msg_len,
   output logic [255:0]            hash_out,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   localparam int unsigned NBLK_MAX = (MAX_MSG_BITS + 64) / 512 + 1;
   localparam int unsigned PW       = NBLK_MAX * 512;
   localparam int unsigned KW       = $clog2(NBLK_MAX + 1);
   localparam logic [255:0] SM3_IV  =
      256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
      return (x << s) | (x >> (6'd32 - {1'b0, s}));
   endfunction

   function automatic logic [31:0] p0(input logic [31:0] x);
      return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
   endfunction

   function automatic logic [31:0] p1(input logic [31:0] x);
      return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
   endfunction

   typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

   state_e             state_q, state_d;
   logic               cf_start_q, cf_start_d;
   logic [KW-1:0]      k_q, k_d;
   logic [255:0]       iv_q, iv_d, hash_q, hash_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic               cf_active_q, cf_end_q;
   logic [5:0]         rnd_q;
   logic [255:0]       wv_q, wv_next, cf_hash;
   logic [31:0]        w_q [16];
   logic [31:0]        w_new;

   logic [KW-1:0]           n_blk;
   logic [MAX_MSG_BITS-1:0] msg_mask;
   logic [PW-1:0]           pad;
   logic [511:0]            blk;

   // Padding: keep the top len message bits, append the 1 bit, length in the last block.
   assign n_blk    = KW'((32'(len_q) + 32'd64) / 32'd512 + 32'd1);
   assign msg_mask = ~({MAX_MSG_BITS{1'b1}} >> len_q);

   always_comb begin
      pad = {msg & msg_mask, {(PW - MAX_MSG_BITS){1'b0}}};
      pad[PW - 1 - 32'(len_q)] = 1'b1;
      blk = pad[PW - 1 - 32'(k_q) * 512 -: 512];
      if (k_q == n_blk - KW'(1)) blk[63:0] = 64'(len_q);
   end

   // One compression round; w_q[0] holds W_j, w_q[4] holds W_(j+4).
   logic [31:0] ra, rb, rc, rd, re, rf, rg, rh;
   logic [31:0] tj, a12, ss1, ss2, ff, gg, tt1, tt2;

   always_comb begin
      {ra, rb, rc, rd, re, rf, rg, rh} = wv_q;
      tj  = (rnd_q < 6'd16) ? 32'h79cc4519 : 32'h7a879d8a;
      a12 = rotl(ra, 5'd12);
      ss1 = rotl(a12 + re + rotl(tj, rnd_q[4:0]), 5'd7);
      ss2 = ss1 ^ a12;
      if (rnd_q < 6'd16) begin
         ff = ra ^ rb ^ rc;
         gg = re ^ rf ^ rg;
      end else begin
         ff = (ra & rb) | (ra & rc) | (rb & rc);
         gg = (re & rf) | (~re & rg);
      end
      tt1     = ff + rd + ss2 + (w_q[0] ^ w_q[4]);
      tt2     = gg + rh + ss1 + w_q[0];
      wv_next = {tt1, ra, rotl(rb, 5'd9), rc, p0(tt2), re, rotl(rf, 5'd19), rg};
      w_new   = p1(w_q[0] ^ w_q[7] ^ rotl(w_q[13], 5'd15)) ^ rotl(w_q[3], 5'd7) ^ w_q[10];
   end

   assign cf_hash = iv_q ^ wv_q;

   // Compression core: loads on a level cf_start, pulses cf_end; waits for cf_start to drop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cf_active_q <= 1'b0;
         cf_end_q    <= 1'b0;
         rnd_q       <= '0;
         wv_q        <= '0;
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         cf_end_q <= 1'b0;
         if (cf_active_q) begin
            wv_q  <= wv_next;
            rnd_q <= rnd_q + 6'd1;
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
            w_q[15] <= w_new;
            if (rnd_q == 6'd63) begin
               cf_active_q <= 1'b0;
               cf_end_q    <= 1'b1;
            end
         end else if (cf_start_q && !cf_end_q) begin
            wv_q        <= iv_q;
            rnd_q       <= '0;
            cf_active_q <= 1'b1;
            for (int i = 0; i < 16; i++) w_q[i] <= blk[511 - 32*i -: 32];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cf_start_d = cf_start_q;
      k_d        = k_q;
      iv_d       = iv_q;
      len_d      = len_q;
      hash_d     = hash_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (msg_len > LEN_W'(MAX_MSG_BITS)) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  len_d      = msg_len;
                  iv_d       = SM3_IV;
                  k_d        = '0;
                  busy_d     = 1'b1;
                  cf_start_d = 1'b1;
                  state_d    = StRun;
               end
            end
         end
         StRun: begin
            if (cf_end_q) begin
               iv_d       = cf_hash;
               cf_start_d = 1'b0;
               k_d        = k_q + KW'(1);
               state_d    = (k_q == n_blk - KW'(1)) ? StDone : StGap;
            end
         end
         StGap: begin
            cf_start_d = 1'b1;
            state_d    = StRun;
         end
         StDone: begin
            hash_d  = iv_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cf_start_q <= 1'b0;
         k_q        <= '0;
         iv_q       <= SM3_IV;
         len_q      <= '0;
         hash_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cf_start_q <= cf_start_d;
         k_q        <= k_d;
         iv_q       <= iv_d;
         len_q      <= len_d;
         hash_q     <= hash_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign hash_out = hash_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_sm3_hash_varlen.sv
// Self-checking bench for sm3_hash_varlen: textbook SM3 reference plus a cycle-level
// expectation of busy/done/err/hash_out, with directed vectors and randomized messages.
module tb_sm3_hash_varlen;
   localparam int T_CF = 65;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [767:0] msg = '0;
   logic [15:0]  msg_len = '0;
   logic [255:0] hash_out;
   logic         busy, done, err;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   sm3_hash_varlen dut (
      .clk(clk), .reset(reset), .start(start), .msg(msg), .msg_len(msg_len),
      .hash_out(hash_out), .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      int s;
      s = n % 32;
      return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
   endfunction

   function automatic logic [31:0] p0f(input logic [31:0] x);
      return x ^ rl(x, 9) ^ rl(x, 17);
   endfunction

   function automatic logic [31:0] p1f(input logic [31:0] x);
      return x ^ rl(x, 15) ^ rl(x, 23);
   endfunction

   function automatic int nblocks(input int len);
      return (len + 64) / 512 + 1;
   endfunction

   // Textbook SM3: explicit bitwise padding, full 68-word expansion per block.
   function automatic logic [255:0] sm3_ref(input logic [767:0] m, input int len);
      logic [1023:0] p;
      logic [511:0]  b;
      logic [31:0]   w [68];
      logic [31:0]   v [8];
      logic [31:0]   r [8];
      logic [31:0]   t, ss1, ss2, ff, gg, tt1, tt2;
      int            n;
      p = '0;
      for (int i = 0; i < len; i++) p[1023 - i] = m[767 - i];
      p[1023 - len] = 1'b1;
      n = nblocks(len);
      p[1024 - 512*n +: 64] = 64'(len);
      v = '{32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
            32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e};
      for (int bn = 0; bn < n; bn++) begin
         b = p[1023 - 512*bn -: 512];
         for (int j = 0; j < 16; j++) w[j] = b[511 - 32*j -: 32];
         for (int j = 16; j < 68; j++)
            w[j] = p1f(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
         r = v;
         for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rl(rl(r[0], 12) + r[4] + rl(t, j), 7);
            ss2 = ss1 ^ rl(r[0], 12);
            ff  = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
            gg  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
            tt1 = ff + r[3] + ss2 + (w[j] ^ w[j+4]);
            tt2 = gg + r[7] + ss1 + w[j];
            r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
            r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4]; r[4] = p0f(tt2);
         end
         for (int i = 0; i < 8; i++) v[i] = v[i] ^ r[i];
      end
      return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
   endfunction

   // Cycle-level expectation of the outputs.
   logic         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
   logic [255:0] m_hash = '0, m_pend = '0;
   int           m_left = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_hash <= '0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         m_err  <= 1'b0;
         if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0; m_done <= 1'b1; m_hash <= m_pend;
            end
         end else if (start) begin
            if (msg_len > 16'd768) begin
               m_done <= 1'b1; m_err <= 1'b1;
            end else begin
               m_busy <= 1'b1;
               m_left <= nblocks(int'(msg_len)) * (T_CF + 2);
               m_pend <= sm3_ref(msg, int'(msg_len));
            end
         end
      end
   end

   always @(negedge clk)
      if (chk_en)
         check("cycle", {busy, done, err, 1'b0, hash_out}, {m_busy, m_done, m_err, 1'b0, m_hash});

   int   cf_rises = 0;
   logic cf_prev = 1'b0;
   always @(negedge clk) begin
      if (dut.cf_start_q && !cf_prev) cf_rises <= cf_rises + 1;
      cf_prev <= dut.cf_start_q;
   end

   task automatic pulse_start(input logic [767:0] m, input int len);
      @(posedge clk); #1;
      msg = m; msg_len = 16'(len); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Start during the current (done) cycle; assumes the caller is at a negedge.
   task automatic start_now(input logic [767:0] m, input int len);
      msg = m; msg_len = 16'(len); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, output int cyc);
      cyc = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cyc++;
         if (done) return;
      end
      check({name, "_timeout"}, 260'(0), 260'(1));
   endtask

   function automatic logic [767:0] rand_msg();
      logic [767:0] m;
      for (int i = 0; i < 24; i++) m[32*i +: 32] = $urandom();
      return m;
   endfunction

   localparam logic [255:0] H_ABC  =
      256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
   localparam logic [255:0] H_NULL =
      256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b;
   localparam logic [255:0] H_ABCD =
      256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [767:0] m_abc, m_abcd, m;
      logic [255:0] h_prev;
      int cyc, base, len;

      m_abc = '0;  m_abc[767 -: 24] = 24'h616263;
      m_abcd = '0; m_abcd[767 -: 512] = {16{32'h61626364}};

      check("ref_abc", 260'(sm3_ref(m_abc, 24)), 260'(H_ABC));
      check("ref_null", 260'(sm3_ref(rand_msg(), 0)), 260'(H_NULL));
      check("ref_abcd", 260'(sm3_ref(m_abcd, 512)), 260'(H_ABCD));

      #2 reset = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      @(negedge clk);
      check("reset_state", {busy, done, err, 1'b0, hash_out}, 260'(0));

      // "abc"
      base = cf_rises;
      pulse_start(m_abc, 24);
      wait_done("abc", 300, cyc);
      check("abc_hash", 260'(hash_out), 260'(H_ABC));
      check("abc_err", 260'(err), 260'(0));
      check("abc_latency", 260'(cyc), 260'(1 * (T_CF + 2) + 1));
      check("abc_cf_passes", 260'(cf_rises - base), 260'(1));

      // Empty message, garbage below the length boundary.
      base = cf_rises;
      pulse_start(rand_msg(), 0);
      wait_done("null", 300, cyc);
      check("null_hash", 260'(hash_out), 260'(H_NULL));
      check("null_cf_passes", 260'(cf_rises - base), 260'(1));

      // "abcd" x16: two blocks
      base = cf_rises;
      pulse_start(m_abcd, 512);
      wait_done("abcd", 300, cyc);
      check("abcd_hash", 260'(hash_out), 260'(H_ABCD));
      check("abcd_latency", 260'(cyc), 260'(2 * (T_CF + 2) + 1));
      check("abcd_cf_passes", 260'(cf_rises - base), 260'(2));

      // 447 vs 448 boundary
      for (int l = 447; l <= 448; l++) begin
         m = rand_msg();
         base = cf_rises;
         pulse_start(m, l);
         wait_done("pad_boundary", 300, cyc);
         check("pad_boundary_hash", 260'(hash_out), 260'(sm3_ref(m, l)));
         check("pad_boundary_passes", 260'(cf_rises - base), 260'((l == 447) ? 1 : 2));
      end

      // Over-length request
      h_prev = hash_out;
      base = cf_rises;
      pulse_start(rand_msg(), 769);
      wait_done("overlen", 5, cyc);
      check("overlen_err", 260'(err), 260'(1));
      check("overlen_latency", 260'(cyc), 260'(1));
      check("overlen_hash_kept", 260'(hash_out), 260'(h_prev));
      @(negedge clk);
      check("overlen_cf_passes", 260'(cf_rises - base), 260'(0));

      // Reset mid-run, then rerun "abc" with stray start pulses while busy
      pulse_start(m_abc, 24);
      repeat (30) @(posedge clk);
      #3 reset = 1'b0;
      @(negedge clk);
      check("midreset_outputs", {busy, done, err, 1'b0, hash_out}, 260'(0));
      @(posedge clk); #3 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("midreset_no_done", {busy, done, err, 1'b0, hash_out}, 260'(0));
      pulse_start(m_abc, 24);
      repeat (10) @(posedge clk);
      #1 msg_len = 16'd0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1 msg_len = 16'd769; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done("rerun", 300, cyc);
      check("rerun_hash", 260'(hash_out), 260'(H_ABC));
      check("rerun_err", 260'(err), 260'(0));

      // Randomized messages, boundary lengths mixed in, some back-to-back
      for (int it = 0; it < 24; it++) begin
         case (it % 8)
            0: len = 768;
            1: len = 511;
            2: len = $urandom_range(769, 1000);
            default: len = $urandom_range(0, 768);
         endcase
         m = rand_msg();
         if (it % 2 == 1) start_now(m, len);
         else pulse_start(m, len);
         wait_done("rand", 300, cyc);
         if (len <= 768) begin
            check("rand_hash", 260'(hash_out), 260'(sm3_ref(m, len)));
            check("rand_latency", 260'(cyc), 260'(nblocks(len) * (T_CF + 2) + 1));
         end else begin
            check("rand_err", 260'(err), 260'(1));
         end
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
